// File: rtl/tablero_buscaminas.sv
// tablero_buscaminas
// Board datapath for the minesweeper game. Holds an 8x8 board as three 64-bit
// vectors (bomb, revealed, flag; index = fila*8+col), places BOMBAS bombs from
// a free-running LFSR, and applies the game controller's one-hot enables
// (move, select, reveal, flag). It answers with the status flags the
// controller branches on, and offers a combinational read port for the display.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enable_matriz            level: (re)generate the board
//   enable_mov               pulse: move cursor one step in dir
//   enable_seleccion         pulse: latch cursor as the selected cell
//   enable_casillas          pulse: reveal the selected cell
//   enable_bandera           pulse: toggle the flag under the cursor
//   boton_mov, dir           user move request and direction (00 up, 01 down, 10 left, 11 right)
//   lectura_fila/col         display read address
//   tableroGenerado          board ready (registered)
//   movimientoValido         boton_mov and move target inside the board
//   bomba                    selected cell holds an unflagged bomb
//   esVictoria               every safe cell has been revealed
//   cursor_fila/col          cursor position
//   celda_revelada/bandera/bomba, celda_vecinas   state of the read cell
module tablero_buscaminas #(
  parameter int          BOMBAS  = 10,
  parameter logic [15:0] SEMILLA = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_matriz,
  input  logic       enable_mov,
  input  logic       enable_seleccion,
  input  logic       enable_casillas,
  input  logic       enable_bandera,
  input  logic       boton_mov,
  input  logic [1:0] dir,
  input  logic [2:0] lectura_fila,
  input  logic [2:0] lectura_col,
  output logic       tableroGenerado,
  output logic       movimientoValido,
  output logic       bomba,
  output logic       esVictoria,
  output logic [2:0] cursor_fila,
  output logic [2:0] cursor_col,
  output logic       celda_revelada,
  output logic       celda_bandera,
  output logic       celda_bomba,
  output logic [3:0] celda_vecinas
);

  typedef enum logic [1:0] {S_IDLE, S_LIMPIAR, S_COLOCAR, S_LISTO} estado_t;

  localparam logic [5:0] BOMBAS_L = 6'(BOMBAS);
  localparam logic [6:0] SEGURAS  = 7'(64 - BOMBAS);

  estado_t     r_estado;
  logic [15:0] r_lfsr;
  logic [63:0] r_bomba;
  logic [63:0] r_revelada;
  logic [63:0] r_bandera;
  logic [5:0]  r_nbombas;
  logic [6:0]  r_reveladas;
  logic [2:0]  r_cur_fila;
  logic [2:0]  r_cur_col;
  logic [2:0]  r_sel_fila;
  logic [2:0]  r_sel_col;
  logic        r_tableroGenerado;

  logic        w_fb;
  logic [5:0]  w_cand;
  logic [5:0]  w_sel;
  logic [5:0]  w_cur;
  logic [5:0]  w_lect;
  logic        w_dentro;
  logic        w_juego;
  logic [3:0]  w_vecinas;
  int          w_nr;
  int          w_nc;

  // Fibonacci feedback for taps 16,14,13,11 (bits 15,13,12,10).
  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand = r_lfsr[5:0];
  assign w_sel  = {r_sel_fila, r_sel_col};
  assign w_cur  = {r_cur_fila, r_cur_col};
  assign w_lect = {lectura_fila, lectura_col};

  // Player enables only act on a stable board and while no new board is
  // being requested (a held enable_matriz outranks every other enable).
  assign w_juego = ((r_estado == S_IDLE) || (r_estado == S_LISTO)) && !enable_matriz;

  // The LFSR never stops, so bomb placement depends on when the player starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEMILLA;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  // Move target check: the step must stay on the board.
  always_comb begin
    w_dentro = 1'b0;
    unique case (dir)
      2'b00: w_dentro = (r_cur_fila != 3'd0);
      2'b01: w_dentro = (r_cur_fila != 3'd7);
      2'b10: w_dentro = (r_cur_col  != 3'd0);
      2'b11: w_dentro = (r_cur_col  != 3'd7);
    endcase
  end

  // Generator FSM plus all board state. LIMPIAR wipes the board, COLOCAR drops
  // one bomb per cycle on any free candidate cell and only declares the board
  // ready on the cycle after the last bomb lands. In IDLE/LISTO the game
  // enables are applied in priority order casillas > seleccion > bandera > mov.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado          <= S_IDLE;
      r_bomba           <= '0;
      r_revelada        <= '0;
      r_bandera         <= '0;
      r_nbombas         <= '0;
      r_reveladas       <= '0;
      r_cur_fila        <= '0;
      r_cur_col         <= '0;
      r_sel_fila        <= '0;
      r_sel_col         <= '0;
      r_tableroGenerado <= 1'b0;
    end else begin
      unique case (r_estado)
        S_IDLE: begin
          if (enable_matriz) r_estado <= S_LIMPIAR;
        end
        S_LIMPIAR: begin
          r_bomba     <= '0;
          r_revelada  <= '0;
          r_bandera   <= '0;
          r_nbombas   <= '0;
          r_reveladas <= '0;
          r_cur_fila  <= '0;
          r_cur_col   <= '0;
          r_estado    <= S_COLOCAR;
        end
        S_COLOCAR: begin
          if (r_nbombas == BOMBAS_L) begin
            r_estado          <= S_LISTO;
            r_tableroGenerado <= 1'b1;
          end else if (!r_bomba[w_cand]) begin
            r_bomba[w_cand] <= 1'b1;
            r_nbombas       <= r_nbombas + 6'd1;
          end
        end
        S_LISTO: begin
          if (!enable_matriz) begin
            r_estado          <= S_IDLE;
            r_tableroGenerado <= 1'b0;
          end
        end
        default: r_estado <= S_IDLE;
      endcase

      if (w_juego) begin
        if (enable_casillas) begin
          if (!r_revelada[w_sel] && !r_bandera[w_sel]) begin
            r_revelada[w_sel] <= 1'b1;
            r_reveladas       <= r_reveladas + 7'd1;
          end
        end else if (enable_seleccion) begin
          r_sel_fila <= r_cur_fila;
          r_sel_col  <= r_cur_col;
        end else if (enable_bandera) begin
          if (!r_revelada[w_cur]) r_bandera[w_cur] <= ~r_bandera[w_cur];
        end else if (enable_mov && w_dentro) begin
          unique case (dir)
            2'b00: r_cur_fila <= r_cur_fila - 3'd1;
            2'b01: r_cur_fila <= r_cur_fila + 3'd1;
            2'b10: r_cur_col  <= r_cur_col  - 3'd1;
            2'b11: r_cur_col  <= r_cur_col  + 3'd1;
          endcase
        end
      end
    end
  end

  // Neighbour bomb count of the read cell; off-board offsets and the cell
  // itself are skipped.
  always_comb begin
    w_vecinas = '0;
    w_nr      = 0;
    w_nc      = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        w_nr = int'(lectura_fila) + dr;
        w_nc = int'(lectura_col) + dc;
        if ((w_nr >= 0) && (w_nr < 8) && (w_nc >= 0) && (w_nc < 8) && !((dr == 0) && (dc == 0))) begin
          w_vecinas = w_vecinas + {3'b000, r_bomba[{w_nr[2:0], w_nc[2:0]}]};
        end
      end
    end
  end

  assign tableroGenerado  = r_tableroGenerado;
  assign movimientoValido = boton_mov & w_dentro;
  assign bomba            = r_bomba[w_sel] & ~r_bandera[w_sel];
  assign esVictoria       = (r_reveladas == SEGURAS);
  assign cursor_fila      = r_cur_fila;
  assign cursor_col       = r_cur_col;
  assign celda_revelada   = r_revelada[w_lect];
  assign celda_bandera    = r_bandera[w_lect];
  assign celda_bomba      = r_bomba[w_lect];
  assign celda_vecinas    = w_vecinas;

endmodule

// File: tb/tb_tablero_buscaminas.sv
// tb_tablero_buscaminas
// Drives two boards side by side: A with 10 bombs for generation, cursor
// bounds, reveal, flag and mid-generation reset; B with 63 bombs for the
// victory condition. Expected values are queued when stimulus is applied and
// compared when the outputs are sampled on the falling clock edge.
module tb_tablero_buscaminas;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, matA, movA, selA, casA, banA, botA;
  logic [1:0] dirA;
  logic [2:0] lfA, lcA;
  logic       genA, validA, bombaA, vicA, revA, flagA, bombA;
  logic [2:0] cfA, ccA;
  logic [3:0] vecA;

  logic       rstB, matB, movB, selB, casB, banB, botB;
  logic [1:0] dirB;
  logic [2:0] lfB, lcB;
  logic       genB, validB, bombaB, vicB, revB, flagB, bombB;
  logic [2:0] cfB, ccB;
  logic [3:0] vecB;

  tablero_buscaminas #(.BOMBAS(10), .SEMILLA(16'hACE1)) u_dutA (
    .clk(clk), .rst(rstA), .enable_matriz(matA), .enable_mov(movA),
    .enable_seleccion(selA), .enable_casillas(casA), .enable_bandera(banA),
    .boton_mov(botA), .dir(dirA), .lectura_fila(lfA), .lectura_col(lcA),
    .tableroGenerado(genA), .movimientoValido(validA), .bomba(bombaA),
    .esVictoria(vicA), .cursor_fila(cfA), .cursor_col(ccA),
    .celda_revelada(revA), .celda_bandera(flagA), .celda_bomba(bombA),
    .celda_vecinas(vecA)
  );

  tablero_buscaminas #(.BOMBAS(63), .SEMILLA(16'hACE1)) u_dutB (
    .clk(clk), .rst(rstB), .enable_matriz(matB), .enable_mov(movB),
    .enable_seleccion(selB), .enable_casillas(casB), .enable_bandera(banB),
    .boton_mov(botB), .dir(dirB), .lectura_fila(lfB), .lectura_col(lcB),
    .tableroGenerado(genB), .movimientoValido(validB), .bomba(bombaB),
    .esVictoria(vicB), .cursor_fila(cfB), .cursor_col(ccB),
    .celda_revelada(revB), .celda_bandera(flagB), .celda_bomba(bombB),
    .celda_vecinas(vecB)
  );

  typedef struct {
    string tag;
    int    val;
  } expT;

  expT sbQ[$];
  int  nCompared   = 0;
  int  nMismatched = 0;
  int  curF[2];
  int  curC[2];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input string tag, input int val);
    expT e;
    e.tag = tag;
    e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic popAndCheck(input int observed);
    expT e;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", observed, -1);
    end else begin
      e = sbQ.pop_front();
      checkOutput(e.tag, observed, e.val);
    end
  endtask

  // which: 0 mov, 1 seleccion, 2 casillas, 3 bandera, 4 matriz
  task automatic applyStimulus(input int u, input int which, input logic v);
    if (u == 0) begin
      case (which)
        0: movA = v;
        1: selA = v;
        2: casA = v;
        3: banA = v;
        default: matA = v;
      endcase
    end else begin
      case (which)
        0: movB = v;
        1: selB = v;
        2: casB = v;
        3: banB = v;
        default: matB = v;
      endcase
    end
  endtask

  task automatic pulse(input int u, input int which);
    @(negedge clk);
    applyStimulus(u, which, 1'b1);
    @(negedge clk);
    applyStimulus(u, which, 1'b0);
  endtask

  task automatic setDir(input int u, input int d);
    if (u == 0) begin dirA = 2'(d); botA = 1'b1; end
    else        begin dirB = 2'(d); botB = 1'b1; end
  endtask

  function automatic int genOf(input int u);
    return (u == 0) ? int'(genA) : int'(genB);
  endfunction

  function automatic int validOf(input int u);
    return (u == 0) ? int'(validA) : int'(validB);
  endfunction

  function automatic int bombaOf(input int u);
    return (u == 0) ? int'(bombaA) : int'(bombaB);
  endfunction

  function automatic int vicOf(input int u);
    return (u == 0) ? int'(vicA) : int'(vicB);
  endfunction

  function automatic int cursorOf(input int u);
    return (u == 0) ? int'({cfA, ccA}) : int'({cfB, ccB});
  endfunction

  function automatic int vecinasModel(input bit [63:0] map, input int idx);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int r = idx / 8 + dr;
        int c = idx % 8 + dc;
        if (r >= 0 && r < 8 && c >= 0 && c < 8 && !(dr == 0 && dc == 0))
          n += int'(map[r * 8 + c]);
      end
    return n;
  endfunction

  task automatic readCell(input int u, input int idx, output int rev, output int ban,
                          output int bom, output int vec);
    if (u == 0) begin lfA = 3'(idx / 8); lcA = 3'(idx % 8); end
    else        begin lfB = 3'(idx / 8); lcB = 3'(idx % 8); end
    #1;
    if (u == 0) begin rev = int'(revA); ban = int'(flagA); bom = int'(bombA); vec = int'(vecA); end
    else        begin rev = int'(revB); ban = int'(flagB); bom = int'(bombB); vec = int'(vecB); end
  endtask

  task automatic readMap(input int u, output bit [63:0] map, output int nRev, output int nFlag);
    int rev, ban, bom, vec;
    map = '0;
    nRev = 0;
    nFlag = 0;
    for (int i = 0; i < 64; i++) begin
      readCell(u, i, rev, ban, bom, vec);
      map[i] = bom[0];
      nRev  += rev;
      nFlag += ban;
    end
  endtask

  // Holds enable_matriz until the board reports ready (bounded), then drops it.
  task automatic generateBoard(input int u, input int bombas, input int budget);
    int cycles = 0;
    @(negedge clk);
    applyStimulus(u, 4, 1'b1);
    do begin
      @(negedge clk);
      cycles++;
    end while (genOf(u) == 0 && cycles < budget);
    pushExpected("gen_ready", 1);
    popAndCheck(genOf(u));
    pushExpected("gen_not_early", 1);
    popAndCheck(int'(cycles >= bombas + 3));
    applyStimulus(u, 4, 1'b0);
    pushExpected("gen_held_until_edge", 1);
    popAndCheck(genOf(u));
    @(negedge clk);
    pushExpected("gen_drop", 0);
    popAndCheck(genOf(u));
    curF[u] = 0;
    curC[u] = 0;
  endtask

  task automatic moveTo(input int u, input int target);
    int tf = target / 8;
    int tc = target % 8;
    while (curF[u] != tf) begin
      int stepDown = (curF[u] < tf);
      setDir(u, stepDown ? 1 : 0);
      pulse(u, 0);
      curF[u] += stepDown ? 1 : -1;
    end
    while (curC[u] != tc) begin
      int stepRight = (curC[u] < tc);
      setDir(u, stepRight ? 3 : 2);
      pulse(u, 0);
      curC[u] += stepRight ? 1 : -1;
    end
    pushExpected("cursor_move", target);
    popAndCheck(cursorOf(u));
  endtask

  bit [63:0] mapA, mapB;
  int        nRev, nFlag, rev, ban, bom, vec, safe, bmb, popc;

  initial begin
    {matA, movA, selA, casA, banA, botA, dirA, lfA, lcA} = '0;
    {matB, movB, selB, casB, banB, botB, dirB, lfB, lcB} = '0;
    rstA = 1'b1;
    rstB = 1'b1;
    curF = '{0, 0};
    curC = '{0, 0};
    #2;

    // Reset state
    botA = 1'b1; dirA = 2'b00;
    botB = 1'b1; dirB = 2'b01;
    lfA = 3'd3; lcA = 3'd4;
    #1;
    pushExpected("rst_gen", 0);        popAndCheck(genOf(0));
    pushExpected("rst_bomba", 0);      popAndCheck(bombaOf(0));
    pushExpected("rst_victoria", 0);   popAndCheck(vicOf(0));
    pushExpected("rst_cursor", 0);     popAndCheck(cursorOf(0));
    pushExpected("rst_valid_up", 0);   popAndCheck(validOf(0));
    pushExpected("rst_valid_down", 1); popAndCheck(validOf(1));
    pushExpected("rst_celda", 0);      popAndCheck(int'({revA, flagA, bombA, vecA}));
    pushExpected("rst_victoria_b", 0); popAndCheck(vicOf(1));
    @(negedge clk);
    rstA = 1'b0;
    rstB = 1'b0;

    // Board A generation
    generateBoard(0, 10, 200);
    readMap(0, mapA, nRev, nFlag);
    popc = $countones(mapA);
    pushExpected("popcount_a", 10); popAndCheck(popc);
    pushExpected("revealed_a", 0);  popAndCheck(nRev);
    pushExpected("flags_a", 0);     popAndCheck(nFlag);
    for (int i = 0; i < 64; i += 9) begin
      readCell(0, i, rev, ban, bom, vec);
      pushExpected($sformatf("vecinas_a_%0d", i), vecinasModel(mapA, i));
      popAndCheck(vec);
    end

    // Cursor bounds
    setDir(0, 0); #1;
    pushExpected("valid_up_at_top", 0); popAndCheck(validOf(0));
    pulse(0, 0);
    pushExpected("cursor_held", 0); popAndCheck(cursorOf(0));
    setDir(0, 2); #1;
    pushExpected("valid_left_at_edge", 0); popAndCheck(validOf(0));
    setDir(0, 3); #1;
    pushExpected("valid_right", 1); popAndCheck(validOf(0));
    pulse(0, 0);
    curC[0] = 1;
    pushExpected("cursor_right", 1); popAndCheck(cursorOf(0));
    botA = 1'b0; #1;
    pushExpected("valid_no_button", 0); popAndCheck(validOf(0));

    // Reveal a safe cell, twice
    safe = 0;
    while (mapA[safe]) safe++;
    bmb = 0;
    while (!mapA[bmb]) bmb++;
    moveTo(0, safe);
    pulse(0, 1);
    pulse(0, 2);
    pushExpected("bomba_safe", 0); popAndCheck(bombaOf(0));
    readCell(0, safe, rev, ban, bom, vec);
    pushExpected("revealed_safe", 1); popAndCheck(rev);
    pushExpected("count_after_reveal", 1); popAndCheck(int'(u_dutA.r_reveladas));
    pulse(0, 2);
    pushExpected("count_second_reveal", 1); popAndCheck(int'(u_dutA.r_reveladas));

    // Flag a bomb, select it, try to reveal it, unflag it
    moveTo(0, bmb);
    pulse(0, 3);
    readCell(0, bmb, rev, ban, bom, vec);
    pushExpected("flag_set", 1); popAndCheck(ban);
    pulse(0, 1);
    pushExpected("bomba_flagged", 0); popAndCheck(bombaOf(0));
    pulse(0, 2);
    readCell(0, bmb, rev, ban, bom, vec);
    pushExpected("flagged_not_revealed", 0); popAndCheck(rev);
    pushExpected("count_flagged", 1); popAndCheck(int'(u_dutA.r_reveladas));
    pulse(0, 3);
    pushExpected("bomba_unflagged", 1); popAndCheck(bombaOf(0));

    // Flag on a revealed cell has no effect
    moveTo(0, safe);
    pulse(0, 3);
    readCell(0, safe, rev, ban, bom, vec);
    pushExpected("flag_on_revealed", 0); popAndCheck(ban);
    pushExpected("victoria_a", 0); popAndCheck(vicOf(0));

    // Reset in the middle of bomb placement
    @(negedge clk);
    applyStimulus(0, 4, 1'b1);
    repeat (5) @(negedge clk);
    rstA = 1'b1;
    applyStimulus(0, 4, 1'b0);
    @(negedge clk);
    pushExpected("midrst_gen", 0);    popAndCheck(genOf(0));
    pushExpected("midrst_cursor", 0); popAndCheck(cursorOf(0));
    pushExpected("midrst_bomba", 0);  popAndCheck(bombaOf(0));
    pushExpected("midrst_count", 0);  popAndCheck(int'(u_dutA.r_reveladas));
    readMap(0, mapA, nRev, nFlag);
    pushExpected("midrst_bombs", 0);  popAndCheck($countones(mapA));
    pushExpected("midrst_state", 0);  popAndCheck(nRev + nFlag);
    @(negedge clk);
    rstA = 1'b0;
    generateBoard(0, 10, 200);
    readMap(0, mapA, nRev, nFlag);
    pushExpected("regen_popcount", 10); popAndCheck($countones(mapA));
    pushExpected("regen_clean", 0);     popAndCheck(nRev + nFlag);

    // Board B: 63 bombs, one safe cell, reveal it to win
    generateBoard(1, 63, 20000);
    readMap(1, mapB, nRev, nFlag);
    pushExpected("popcount_b", 63); popAndCheck($countones(mapB));
    safe = 0;
    while (safe < 63 && mapB[safe]) safe++;
    pushExpected("bomba_b_initial_sel", int'(mapB[0])); popAndCheck(bombaOf(1));
    pushExpected("victoria_b_before", 0); popAndCheck(vicOf(1));
    moveTo(1, safe);
    pulse(1, 1);
    pulse(1, 2);
    pushExpected("victoria_b", 1); popAndCheck(vicOf(1));
    pushExpected("bomba_b_safe", 0); popAndCheck(bombaOf(1));
    readCell(1, safe, rev, ban, bom, vec);
    pushExpected("vecinas_b_safe", vecinasModel(mapB, safe)); popAndCheck(vec);
    readCell(1, 0, rev, ban, bom, vec);
    pushExpected("vecinas_b_corner", (safe == 1 || safe == 8 || safe == 9) ? 2 : 3);
    popAndCheck(vec);
    readCell(1, 27, rev, ban, bom, vec);
    pushExpected("vecinas_b_interior", (vecinasModel(~64'd0, 27) - int'(safe != 27 && vecinasModel(64'd1 << safe, 27) == 1)));
    popAndCheck(vec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/tablero_buscaminas.md
# tablero_buscaminas

Board datapath for the minesweeper game: an 8x8 cell store with bomb placement, cursor, reveal and flag logic. It is the responder to the game-control FSM. It consumes that FSM's one-hot enables (board generation, move, select, reveal, flag) and returns the status flags the FSM branches on (board ready, valid move, bomb hit, victory). A read port serves the VGA/display path.

## Interface
Parameters:
- BOMBAS, 10: bombs placed per game, legal range 1..63.
- SEMILLA, 16'hACE1: LFSR reset value, must be nonzero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable_matriz  in  1  level; generate a new board.
- enable_mov  in  1  one-cycle pulse; move cursor one step in `dir`.
- enable_seleccion  in  1  one-cycle pulse; latch the cursor cell as the selection.
- enable_casillas  in  1  one-cycle pulse; reveal the latched cell.
- enable_bandera  in  1  one-cycle pulse; toggle flag at cursor.
- boton_mov  in  1  user move request.
- dir  in  2  move direction: 00 up (fila-1), 01 down, 10 left (col-1), 11 right.
- lectura_fila, lectura_col  in  3 each  display read address.
- tableroGenerado  out  1  board ready.
- movimientoValido  out  1  boton_mov high and move target in bounds.
- bomba  out  1  selected cell holds an unflagged bomb.
- esVictoria  out  1  all safe cells revealed.
- cursor_fila, cursor_col  out  3 each  cursor position.
- celda_revelada, celda_bandera, celda_bomba  out  1 each  state of the read cell.
- celda_vecinas  out  4  count of bombs among the 8 neighbours of the read cell, 0..8.

## Operation
- Storage: three 64-bit vectors (bomb, revealed, flag), index = fila*8+col. Revealed-count register is 7 bits.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-running every cycle from reset, so board placement depends on player timing. Candidate index = lfsr[5:0]; fila = lfsr[5:3], col = lfsr[2:0].
- Generator FSM:
  - IDLE: if enable_matriz -> LIMPIAR.
  - LIMPIAR: clear all three vectors, bomb counter, revealed count; cursor to (0,0) -> COLOCAR.
  - COLOCAR: if the candidate cell is not a bomb, set it and increment the counter. When the counter reaches BOMBAS -> LISTO.
  - LISTO: tableroGenerado=1; when enable_matriz low -> IDLE.
- While in LIMPIAR or COLOCAR, all other enables are ignored.
- Board contents persist in IDLE/LISTO. They are cleared only in LIMPIAR.
- movimientoValido (combinational) = boton_mov & target in 0..7. On enable_mov with a valid target, the cursor moves one step. On enable_mov with an invalid target, the cursor holds.
- enable_seleccion: latch cursor into sel_fila/sel_col.
- bomba (combinational) = bomb[sel] & ~flag[sel].
- enable_casillas: if sel is neither revealed nor flagged, set revealed[sel] and increment the count. Otherwise no change.
- enable_bandera: toggle flag[cursor] only if the cell is not revealed.
- esVictoria (combinational) = (revealed count == 64-BOMBAS).
- Read port is fully combinational. Neighbour count excludes out-of-board positions and the cell itself.
- Priority if several enables coincide: matriz > casillas > seleccion > bandera > mov.

## Timing
- Reset values:
  - generator state IDLE, tableroGenerado 0.
  - all vectors 0, revealed count 0.
  - cursor (0,0), sel (0,0), LFSR = SEMILLA.
  - Resulting outputs: bomba 0, esVictoria 0, movimientoValido = boton_mov & in-bounds, celda_* 0.
- enable_matriz sampled high at edge k: LIMPIAR at k+1, COLOCAR at k+2. tableroGenerado rises no earlier than edge k+2+BOMBAS.
- Maximal-length LFSR makes the low 6 bits cover all 64 values, so generation always terminates.
- Register updates (cursor, sel, vectors, count) are visible the cycle after the enable edge. The controller sees the new esVictoria/bomba on its next decision.
- rst mid-generation or mid-game: immediate return to reset values. A partial board is discarded.

## Test plan
- Reset, then enable_matriz held, BOMBAS=10:
  - popcount(bomb)==10.
  - tableroGenerado=1 within 200 cycles.
  - drops one cycle after enable_matriz goes low.
  - revealed/flag all 0.
- Bounds: cursor (0,0), boton_mov=1, dir=00 -> movimientoValido=0, and an enable_mov pulse leaves the cursor at (0,0). dir=11 -> movimientoValido=1, cursor (0,1) after pulse.
- Reveal on a known safe cell (read via celda_bomba): seleccion then casillas -> bomba=0, celda_revelada=1, count +1. A second reveal of the same cell leaves the count unchanged.
- Flag a bomb cell, then select it -> bomba=0. Casillas -> not revealed. Bandera on a revealed cell -> flag stays 0.
- BOMBAS=63: reveal the single safe cell -> esVictoria=1. Its celda_vecinas equals its neighbour count: 3 at a corner, 8 in the interior.
- rst pulse during COLOCAR -> all outputs at reset values next cycle. A new enable_matriz regenerates the board fully.
